arqt_nios2_gen2_0_cpu_debug_mem_seq: RTL
========================================

Name: arqt_nios2_gen2_0_cpu_debug_mem_seq

Overview:
System-clock consumer of the debug slave's decoded JTAG commands: the jdo word and the ocimem take-action strobes. Turns each command into one Avalon-style word access on the debug monitor memory. Returns read data as MonDReg, which loops back to the debug slave for scan-out. Adds auto-increment, a bus timeout and sticky error/overrun flags.

Parameters:
ADDR_W, 8, word-address width of the monitor memory (2^ADDR_W words)
TIMEOUT, 255, maximum consecutive waitrequest cycles before an access is aborted (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
jdo  in  38  command/data word from debug slave (sampled only on a strobe cycle)
take_action_ocimem_a  in  1  address/command strobe, 1-cycle pulse
take_action_ocimem_b  in  1  write-data strobe, 1-cycle pulse
take_no_action_ocimem_a  in  1  repeat-read strobe, 1-cycle pulse
mem_address  out  ADDR_W  word address
mem_read  out  1  read request
mem_write  out  1  write request
mem_writedata  out  32  write data
mem_readdata  in  32  read data, valid when mem_read && !mem_waitrequest
mem_waitrequest  in  1  slave stall
MonDReg  out  32  last read data
mon_busy  out  1  access in progress
mon_done  out  1  1-cycle pulse on access completion
mon_error  out  1  sticky timeout flag
mon_overrun  out  1  sticky dropped-command flag

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE.
  - All outputs 0; addr=0, inc=0, wdata=0, timeout count=0.
  - An in-flight access is abandoned; mem_read/mem_write drop at once.
- Field map:
  - addr = jdo[ADDR_W+1:2]
  - inc = jdo[35]
  - rd = jdo[36]
  - write data = jdo[34:3]
- States: IDLE, RD, WR. mon_busy = (state != IDLE), registered.
- IDLE, take_action_ocimem_a:
  - Load addr and inc.
  - Clear mon_error and mon_overrun.
  - If rd=1, go to RD; otherwise stay IDLE (address load only).
- IDLE, take_action_ocimem_b: wdata <= jdo[34:3], go to WR.
- IDLE, take_no_action_ocimem_a: go to RD at the current addr.
- Priority of strobes in the same cycle: a > b > no_action. Each lower strobe is dropped and sets mon_overrun.
- RD: mem_read=1, mem_address=addr.
  - First cycle with !mem_waitrequest: MonDReg <= mem_readdata; mon_done=1 next cycle; IDLE.
- WR: mem_write=1, mem_writedata=wdata.
  - First cycle with !mem_waitrequest: mon_done=1 next cycle; IDLE.
- Auto-increment: post-increment on successful completion when inc=1, for both reads and writes. Wraps 2^ADDR_W-1 -> 0.
- Latency, zero-wait slave:
  - Strobe at cycle N; mem_read/mem_write high in N+1.
  - In N+2: MonDReg valid, mon_done=1, mon_busy=0, mem_read/mem_write=0.
  - Each stall cycle adds 1.
- mem_read and mem_write are never high together. Both are registered, glitch-free, and held with a stable address and data while stalled.
- Timeout:
  - Counter increments for each waitrequest cycle in RD/WR.
  - On the TIMEOUT-th stalled cycle: deassert the request, set mon_error, go to IDLE.
  - On timeout: no mon_done, MonDReg unchanged, addr not incremented.
  - Counter is cleared on entering RD/WR.
- Any strobe while mon_busy=1 is ignored and sets mon_overrun. The current access is unaffected.
- Sticky flags clear only through an accepted take_action_ocimem_a or reset.

Test Plan:
1. Auto-increment write, then read back:
   - Stimulus: A(addr=0x10, inc=1, rd=0); then B with data 0xDEADBEEF and 0x12345678, zero-wait slave.
   - Response: writes land at 0x10 and 0x11; addr ends at 0x12.
   - Stimulus: A(addr=0x10, inc=1, rd=1); then no_action.
   - Response: MonDReg=0xDEADBEEF, then 0x12345678; one mon_done per access at N+2.
2. Stalled read:
   - Stimulus: A(addr=0x05, rd=1), waitrequest held 3 cycles.
   - Response: mem_read high for 4 cycles with address 0x05 stable; mon_done at N+5; mon_error=0.
3. Timeout:
   - Stimulus: TIMEOUT=4, B write, waitrequest stuck high.
   - Response: mem_write drops after 4 cycles; mon_error=1; mon_done never pulses; addr unchanged.
   - Follow-up: next A clears mon_error.
4. Overrun:
   - Stimulus: no_action issued during a stalled RD.
   - Response: mon_overrun=1; exactly one access completes.
   - Stimulus: A and B in the same cycle in IDLE.
   - Response: A executed; mon_overrun=1.
5. Address wrap: A(addr=0xFF, inc=1, rd=1) with ADDR_W=8 -> read at 0xFF; addr becomes 0x00; the next no_action reads 0x00.
6. Reset mid-operation: assert reset during a stalled WR -> mem_write, mon_busy and MonDReg go to 0 in the same cycle; no mon_done after release.

Source files
------------

// File: rtl/arqt_nios2_gen2_0_cpu_debug_mem_seq.sv
// Debug monitor memory sequencer.
// Takes the decoded JTAG commands from the debug slave (jdo word plus the
// ocimem strobes) and turns each one into a single word access on the
// monitor memory. Read data is held in MonDReg for scan-out. Adds address
// auto-increment, a waitrequest timeout and sticky error/overrun flags.
module arqt_nios2_gen2_0_cpu_debug_mem_seq #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              mon_busy,
    output logic              mon_done,
    output logic              mon_error,
    output logic              mon_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              inc;
    logic [31:0]       wdata;
    logic [15:0]       tcount;

    logic              idle;
    logic              acc_a;
    logic              acc_b;
    logic              acc_n;
    logic              dropped;
    logic              timed_out;
    logic              unused_jdo;

    // Post-increment of the word address; wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_incr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    // jdo bits outside the field map carry nothing for this block.
    assign unused_jdo = ^{jdo[37], jdo[1:0]};

    // Strobe arbitration: a beats b beats no_action; only honoured in IDLE.
    // Any strobe that loses arbitration or arrives while busy is dropped.
    always_comb begin
        idle      = (state == IDLE);
        acc_a     = idle & take_action_ocimem_a;
        acc_b     = idle & take_action_ocimem_b & ~take_action_ocimem_a;
        acc_n     = idle & take_no_action_ocimem_a & ~take_action_ocimem_a
                         & ~take_action_ocimem_b;
        if (idle) begin
            dropped = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                    | (take_action_ocimem_b & take_no_action_ocimem_a);
        end else begin
            dropped = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        end
        // This cycle is the TIMEOUT-th consecutive stall of the access.
        timed_out = (tcount == 16'(TIMEOUT - 1));
    end

    assign mem_address   = addr;
    assign mem_writedata = wdata;

    // Command sequencer: registered bus requests, completion and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            inc         <= 1'b0;
            wdata       <= '0;
            tcount      <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            MonDReg     <= '0;
            mon_busy    <= 1'b0;
            mon_done    <= 1'b0;
            mon_error   <= 1'b0;
            mon_overrun <= 1'b0;
        end else begin
            mon_done    <= 1'b0;
            // An accepted A clears overrun, but a strobe it beat still sets it.
            mon_overrun <= (acc_a ? 1'b0 : mon_overrun) | dropped;
            case (state)
                IDLE: begin
                    if (acc_a) begin
                        addr      <= jdo[ADDR_W+1:2];
                        inc       <= jdo[35];
                        mon_error <= 1'b0;
                        if (jdo[36]) begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mon_busy <= 1'b1;
                            tcount   <= '0;
                        end
                    end else if (acc_b) begin
                        wdata     <= jdo[34:3];
                        state     <= WR;
                        mem_write <= 1'b1;
                        mon_busy  <= 1'b1;
                        tcount    <= '0;
                    end else if (acc_n) begin
                        state    <= RD;
                        mem_read <= 1'b1;
                        mon_busy <= 1'b1;
                        tcount   <= '0;
                    end
                end
                RD, WR: begin
                    if (!mem_waitrequest) begin
                        if (state == RD) begin
                            MonDReg <= mem_readdata;
                        end
                        if (inc) begin
                            addr <= addr_incr(addr);
                        end
                        mon_done  <= 1'b1;
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mon_busy  <= 1'b0;
                    end else if (timed_out) begin
                        // Abort: no completion, no read data, no increment.
                        mon_error <= 1'b1;
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mon_busy  <= 1'b0;
                    end else begin
                        tcount <= tcount + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    mon_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
